// File: rtl/breadboard_sweeper_pkg.sv
// Shared types and golden table for the breadboard sweep engine.
// GOLDEN holds {f2,f3,f4,f7} for index i at [i*4 +: 4].
package breadboard_pkg;

  localparam int NUM_VECTORS = 16;

  localparam logic [3:0] LAST_IDX = 4'(NUM_VECTORS - 1);

  localparam logic [63:0] GOLDEN = 64'hE4C1_E150_E510_3800;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } sweep_state_t;

  function automatic logic [3:0] golden_resp(
    input logic [3:0] idx
  );
    return GOLDEN[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/breadboard_sweeper_if.sv
// Stimulus, response and result-stream bundle of the sweeper.
// master = sweeper side, slave = breadboard/host side.
interface breadboard_sweeper_if;

  logic       start;
  logic       w;
  logic       x;
  logic       y;
  logic       z;
  logic       f2;
  logic       f3;
  logic       f4;
  logic       f7;
  logic       busy;
  logic       done;
  logic       vec_valid;
  logic [3:0] vec_idx;
  logic [3:0] vec_resp;
  logic       vec_err;
  logic [4:0] fail_count;
  logic [3:0] first_fail_idx;
  logic       pass;

  modport master (
    input  start,
    input  f2,
    input  f3,
    input  f4,
    input  f7,
    output w,
    output x,
    output y,
    output z,
    output busy,
    output done,
    output vec_valid,
    output vec_idx,
    output vec_resp,
    output vec_err,
    output fail_count,
    output first_fail_idx,
    output pass
  );

  modport slave (
    output start,
    output f2,
    output f3,
    output f4,
    output f7,
    input  w,
    input  x,
    input  y,
    input  z,
    input  busy,
    input  done,
    input  vec_valid,
    input  vec_idx,
    input  vec_resp,
    input  vec_err,
    input  fail_count,
    input  first_fail_idx,
    input  pass
  );

endinterface

// File: rtl/breadboard_sweeper_timer.sv
// Settle down-counter: reloads to SETTLE_CYCLES-1 on DRIVE entry,
// expired when the count reaches zero.
module sweep_settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int unsigned W =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [W-1:0] RELOAD = W'(SETTLE_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/breadboard_sweeper.sv
// Sweeps {w,x,y,z} 0..15, samples {f2,f3,f4,f7}, streams and scores them.
// Define BREADBOARD_SWEEPER_CHECK_EN to build in the golden comparator.
module breadboard_sweeper
  import breadboard_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  breadboard_sweeper_if.master  bus
);

  if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 255)) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..255");
  end

  sweep_state_t state;
  sweep_state_t next;

  logic [3:0] idx;
  logic [3:0] resp;
  logic       mismatch;
  logic       sample_fire;
  logic       accept;
  logic       timer_load;
  logic       timer_en;
  logic       timer_expired;

  logic       vec_valid_q;
  logic [3:0] vec_idx_q;
  logic [3:0] vec_resp_q;
  logic       vec_err_q;
  logic [4:0] fail_count_q;
  logic [3:0] first_fail_q;
  logic       pass_q;

  sweep_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next       = state;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          next = DRIVE;
        end
      end
      DRIVE: begin
        timer_en = 1'b1;
        if (timer_expired) begin
          next = SAMPLE;
        end
      end
      SAMPLE: begin
        next = (idx == LAST_IDX) ? DONE : DRIVE;
      end
      DONE: begin
        next = IDLE;
      end
      default: begin
        next = IDLE;
      end
    endcase
    timer_load = (next == DRIVE) && (state != DRIVE);
  end

  assign sample_fire = (state == SAMPLE);
  assign accept      = (state == IDLE) && bus.start;
  assign resp        = {bus.f2, bus.f3, bus.f4, bus.f7};

`ifdef BREADBOARD_SWEEPER_CHECK_EN
  assign mismatch = (resp != golden_resp(idx));
`else
  assign mismatch = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      vec_valid_q  <= 1'b0;
      vec_idx_q    <= '0;
      vec_resp_q   <= '0;
      vec_err_q    <= 1'b0;
      fail_count_q <= '0;
      first_fail_q <= '0;
      pass_q       <= 1'b0;
    end else begin
      vec_valid_q <= sample_fire;
      vec_err_q   <= sample_fire && mismatch;
      if (sample_fire) begin
        vec_idx_q  <= idx;
        vec_resp_q <= resp;
        idx        <= (idx == LAST_IDX) ? 4'd0 : idx + 4'd1;
        if (mismatch) begin
          if (fail_count_q != 5'(NUM_VECTORS)) begin
            fail_count_q <= fail_count_q + 5'd1;
          end
          if (fail_count_q == '0) begin
            first_fail_q <= idx;
          end
        end
        // Verdict lands with DONE so it is stable alongside the pulse.
        if (idx == LAST_IDX) begin
          pass_q <= (fail_count_q == '0) && !mismatch;
        end
      end else if (accept) begin
        idx          <= '0;
        fail_count_q <= '0;
        first_fail_q <= '0;
        pass_q       <= 1'b0;
      end
    end
  end

  assign {bus.w, bus.x, bus.y, bus.z} = idx;

  assign bus.busy           = (state == DRIVE) || (state == SAMPLE);
  assign bus.done           = (state == DONE);
  assign bus.vec_valid      = vec_valid_q;
  assign bus.vec_idx        = vec_idx_q;
  assign bus.vec_resp       = vec_resp_q;
  assign bus.vec_err        = vec_err_q;
  assign bus.fail_count     = fail_count_q;
  assign bus.first_fail_idx = first_fail_q;
  assign bus.pass           = pass_q;

endmodule

// File: tb/tb_breadboard_sweeper.sv
// Bench for breadboard_sweeper: SETTLE_CYCLES=1 and =4 instances,
// table-driven breadboard model with directed and random faults.
module tb_breadboard_sweeper;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       vv;
    logic       err;
    logic       pass;
    logic [3:0] wxyz;
    logic [3:0] idx;
    logic [3:0] resp;
    logic [4:0] fc;
    logic [3:0] ff;
  } obs_t;

  localparam logic [3:0] GOLD [16] = '{
    4'b0000, 4'b0000, 4'b1000, 4'b0011,
    4'b0000, 4'b0001, 4'b0101, 4'b1110,
    4'b0000, 4'b0101, 4'b0001, 4'b1110,
    4'b0001, 4'b1100, 4'b0100, 4'b1110
  };

  logic clk;
  logic rst_n;
  logic [3:0] tab [2][16];
  int total;
  int bad;

  breadboard_sweeper_if bus1 ();
  breadboard_sweeper_if bus2 ();

  breadboard_sweeper #(.SETTLE_CYCLES(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  breadboard_sweeper #(.SETTLE_CYCLES(4)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  assign {bus1.f2, bus1.f3, bus1.f4, bus1.f7} =
    tab[0][{bus1.w, bus1.x, bus1.y, bus1.z}];
  assign {bus2.f2, bus2.f3, bus2.f4, bus2.f7} =
    tab[1][{bus2.w, bus2.x, bus2.y, bus2.z}];

  obs_t o1;
  obs_t o2;

  assign o1 = {bus1.busy, bus1.done, bus1.vec_valid, bus1.vec_err,
               bus1.pass, bus1.w, bus1.x, bus1.y, bus1.z,
               bus1.vec_idx, bus1.vec_resp, bus1.fail_count,
               bus1.first_fail_idx};
  assign o2 = {bus2.busy, bus2.done, bus2.vec_valid, bus2.vec_err,
               bus2.pass, bus2.w, bus2.x, bus2.y, bus2.z,
               bus2.vec_idx, bus2.vec_resp, bus2.fail_count,
               bus2.first_fail_idx};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] ob,
                     input logic [31:0] ex);
    total++;
    assert (ob === ex) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, ob, ex);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) bus1.start = v;
    else          bus2.start = v;
  endtask

  function automatic bit exp_err(input int sel, input int k);
`ifdef BREADBOARD_SWEEPER_CHECK_EN
    return tab[sel][k] != GOLD[k];
`else
    return 1'b0;
`endif
  endfunction

  // Checks every cycle of one sweep against the timing/score rules.
  task automatic run_sweep(input int sel, input int s, input bit extra);
    int d;
    int k;
    int nf;
    int ff;
    bit ev;
    obs_t o;
    nf = 0;
    ff = 0;
    for (int i = 15; i >= 0; i--) begin
      if (exp_err(sel, i)) begin
        nf++;
        ff = i;
      end
    end
    d = 1 + 16 * (s + 1);
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    for (int n = 1; n <= d + 1; n++) begin
      o  = (sel == 0) ? o1 : o2;
      ev = (n >= s + 2) && ((n - 1) % (s + 1) == 0) && (n <= d);
      k  = (n - 1) / (s + 1) - 1;
      chk("busy", 32'(o.busy), 32'(n < d));
      chk("done", 32'(o.done), 32'(n == d));
      chk("wxyz", 32'(o.wxyz), (n < d) ? 32'((n - 1) / (s + 1)) : 32'd0);
      chk("vec_valid", 32'(o.vv), 32'(ev));
      if (ev) begin
        chk("vec_idx", 32'(o.idx), 32'(k));
        chk("vec_resp", 32'(o.resp), 32'(tab[sel][k]));
        chk("vec_err", 32'(o.err), 32'(exp_err(sel, k)));
      end
      if (n == d) begin
        chk("fail_count", 32'(o.fc), 32'(nf));
        chk("pass", 32'(o.pass), 32'(nf == 0));
        if (nf != 0) chk("first_fail_idx", 32'(o.ff), 32'(ff));
      end
      set_start(sel, extra && (n == 5 || n == 20));
      @(negedge clk);
    end
  endtask

  initial begin
    bit found;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus1.start = 1'b0;
    bus2.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tab[0][i] = GOLD[i];
      tab[1][i] = GOLD[i];
    end
    repeat (3) @(negedge clk);
    chk("reset_dut1", 32'(o1), 32'd0);
    chk("reset_dut2", 32'(o2), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_sweep(0, 1, 1'b0);

    for (int i = 0; i < 16; i++) tab[0][i] = GOLD[i] & 4'b1110;
    run_sweep(0, 1, 1'b0);

    run_sweep(1, 4, 1'b0);

    for (int i = 0; i < 16; i++) tab[0][i] = GOLD[i];
    run_sweep(0, 1, 1'b1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) begin
        tab[0][i] = ($urandom_range(0, 2) == 0) ?
                    4'($urandom) : GOLD[i];
      end
      run_sweep(0, 1, 1'b0);
    end

    for (int i = 0; i < 16; i++) tab[0][i] = ~GOLD[i];
    run_sweep(0, 1, 1'b0);

    for (int i = 0; i < 16; i++) tab[1][i] = 4'($urandom);
    run_sweep(1, 4, 1'b0);

    // Held start: back-to-back sweeps, then an asynchronous abort.
    for (int i = 0; i < 16; i++) tab[0][i] = GOLD[i];
    bus1.start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (bus1.done === 1'b1) found = 1'b1;
    end
    chk("hold_done_seen", 32'(found), 32'd1);
    @(negedge clk);
    chk("hold_idle_gap", 32'(o1.busy), 32'd0);
    @(negedge clk);
    chk("hold_restart_busy", 32'(o1.busy), 32'd1);
    chk("hold_restart_wxyz", 32'(o1.wxyz), 32'd0);
    bus1.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_reset_busy", 32'(o1.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 32'(o1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", 32'(o1), 32'd0);
    run_sweep(0, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
